// File: rtl/decoder_n_seq.sv
// decoder_n_seq: N-to-2^N one-hot decoder with a registered output stage and
// valid/ready handshakes on both sides. An optional SCAN mode walks the
// one-hot output from a start address up to LIMIT-1, one beat per output
// handshake.
//
// Optional feature macro: DECODER_N_SEQ_SCAN_EN
//   defined   : mode=1 requests start a SCAN
//   undefined : mode is ignored, every request is a DECODE, busy is tied 0
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready (combinational)
//   A          address (DECODE) or start address (SCAN)
//   mode       0 = DECODE, 1 = SCAN; sampled only on input handshake
//   out_valid  D/err valid
//   out_ready  downstream accepts when out_valid & out_ready
//   D          registered one-hot output; zero when idle or on error
//   err        current beat's address is out of range
//   busy       high while scanning
module decoder_n_seq #(
  parameter int unsigned N     = 5,
  parameter int unsigned LIMIT = 2**N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    A,
  input  logic            mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] D,
  output logic            err,
  output logic            busy
);

  localparam int unsigned OW = 2**N;

  function automatic logic [OW-1:0] onehot(input logic [N-1:0] a);
    logic [OW-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  logic [OW-1:0] r_d;
  logic          r_err;
  logic          r_valid;
  logic          w_accept;
  logic          w_drain;
  logic          w_in_range;

  assign w_drain    = r_valid & out_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_in_range = (32'(A) < LIMIT);

`ifdef DECODER_N_SEQ_SCAN_EN
  typedef enum logic {S_IDLE, S_SCAN} state_t;

  // Counter stops at LIMIT-1, so N bits never overflow even when LIMIT = 2^N.
  localparam logic [N-1:0] LAST = N'(LIMIT - 1);

  state_t       r_state;
  logic [N-1:0] r_cnt;

  assign in_ready = (r_state == S_IDLE) & (!r_valid | out_ready);
  assign busy     = (r_state == S_SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_d     <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      // Accept may coincide with the drain of the previous beat.
      r_valid <= 1'b1;
      if (!w_in_range) begin
        r_d   <= '0;
        r_err <= 1'b1;
      end else begin
        r_d   <= onehot(A);
        r_err <= 1'b0;
        if (mode) begin
          r_state <= S_SCAN;
          r_cnt   <= A;
        end
      end
    end else if (w_drain) begin
      if (r_state == S_SCAN && r_cnt != LAST) begin
        r_cnt <= r_cnt + 1'b1;
        r_d   <= onehot(r_cnt + 1'b1);
      end else begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_d     <= '0;
        r_err   <= 1'b0;
      end
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;

  assign in_ready = !r_valid | out_ready;
  assign busy     = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d     <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_d     <= w_in_range ? onehot(A) : '0;
      r_err   <= !w_in_range;
    end else if (w_drain) begin
      r_valid <= 1'b0;
      r_d     <= '0;
      r_err   <= 1'b0;
    end
  end
`endif

  assign D         = r_d;
  assign err       = r_err;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_decoder_n_seq.sv
module tb_decoder_n_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  A;
  logic        mode;
  logic        out_ready;

  // Full-range instance (LIMIT = 32)
  logic        a_in_valid, a_in_ready, a_out_valid, a_err, a_busy;
  logic [31:0] a_D;
  // Reduced-range instance (LIMIT = 20)
  logic        b_in_valid, b_in_ready, b_out_valid, b_err, b_busy;
  logic [31:0] b_D;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  decoder_n_seq #(.N(5), .LIMIT(32)) u_full (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .A(A), .mode(mode), .out_valid(a_out_valid), .out_ready(out_ready),
    .D(a_D), .err(a_err), .busy(a_busy)
  );

  decoder_n_seq #(.N(5), .LIMIT(20)) u_lim (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .A(A), .mode(mode), .out_valid(b_out_valid), .out_ready(out_ready),
    .D(b_D), .err(b_err), .busy(b_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_d;
    int unsigned beats;

    rst = 1'b1; A = '0; mode = 1'b0; out_ready = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    check_val("rst_valid", {31'b0, a_out_valid}, 32'd0);
    check_val("rst_D", a_D, 32'd0);
    check_val("rst_err", {31'b0, a_err}, 32'd0);
    check_val("rst_busy", {31'b0, a_busy}, 32'd0);
    check_val("rst_ready", {31'b0, a_in_ready}, 32'd1);

    // DECODE A=13
    a_in_valid = 1'b1; A = 5'd13; mode = 1'b0;
    check_val("dec13_ready_pre", {31'b0, a_in_ready}, 32'd1);
    step();
    a_in_valid = 1'b0;
    check_val("dec13_valid", {31'b0, a_out_valid}, 32'd1);
    check_val("dec13_D", a_D, 32'h0000_2000);
    check_val("dec13_err", {31'b0, a_err}, 32'd0);
    check_val("dec13_ready", {31'b0, a_in_ready}, 32'd1);
    step();
    check_val("dec13_drained", {31'b0, a_out_valid}, 32'd0);
    check_val("dec13_D_clr", a_D, 32'd0);

    // DECODE A=31 (top legal address), then stall with out_ready low
    a_in_valid = 1'b1; A = 5'd31; out_ready = 1'b0;
    step();
    a_in_valid = 1'b0; A = 5'd7;
    check_val("dec31_D", a_D, 32'h8000_0000);
    check_val("dec31_stall_ready", {31'b0, a_in_ready}, 32'd0);
    step();
    check_val("dec31_hold_D", a_D, 32'h8000_0000);
    check_val("dec31_hold_valid", {31'b0, a_out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    check_val("dec31_done", {31'b0, a_out_valid}, 32'd0);

    // LIMIT=20: A=25 errors, back-to-back A=19 legal, A=20 errors, A=0
    b_in_valid = 1'b1; A = 5'd25;
    step();
    check_val("lim25_valid", {31'b0, b_out_valid}, 32'd1);
    check_val("lim25_D", b_D, 32'd0);
    check_val("lim25_err", {31'b0, b_err}, 32'd1);
    A = 5'd19;
    check_val("lim_b2b_ready", {31'b0, b_in_ready}, 32'd1);
    step();
    check_val("lim19_D", b_D, 32'h0008_0000);
    check_val("lim19_err", {31'b0, b_err}, 32'd0);
    A = 5'd20;
    step();
    check_val("lim20_D", b_D, 32'd0);
    check_val("lim20_err", {31'b0, b_err}, 32'd1);
    A = 5'd0;
    step();
    b_in_valid = 1'b0;
    check_val("lim0_D", b_D, 32'h0000_0001);
    check_val("lim0_err", {31'b0, b_err}, 32'd0);
    step();
    check_val("lim_idle", {31'b0, b_out_valid}, 32'd0);

`ifdef DECODER_N_SEQ_SCAN_EN
    // SCAN A=28 at full rate
    a_in_valid = 1'b1; A = 5'd28; mode = 1'b1;
    step();
    a_in_valid = 1'b0; mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_d = 32'h1 << (28 + k);
      check_val("scan28_D", a_D, exp_d);
      check_val("scan28_busy", {31'b0, a_busy}, 32'd1);
      check_val("scan28_ready", {31'b0, a_in_ready}, 32'd0);
      step();
    end
    check_val("scan28_end_valid", {31'b0, a_out_valid}, 32'd0);
    check_val("scan28_end_busy", {31'b0, a_busy}, 32'd0);
    check_val("scan28_end_ready", {31'b0, a_in_ready}, 32'd1);

    // SCAN A=2 with out_ready 1,0,0,1,1
    a_in_valid = 1'b1; A = 5'd2; mode = 1'b1;
    step();
    a_in_valid = 1'b0; mode = 1'b0;
    out_ready = 1'b1;
    check_val("scan2_b2", a_D, 32'h0000_0004);
    step();
    out_ready = 1'b0;
    check_val("scan2_b3", a_D, 32'h0000_0008);
    step();
    check_val("scan2_b3_hold1", a_D, 32'h0000_0008);
    step();
    out_ready = 1'b1;
    check_val("scan2_b3_hold2", a_D, 32'h0000_0008);
    step();
    check_val("scan2_b4", a_D, 32'h0000_0010);
    step();
    beats = 0;
    exp_d = 32'h0000_0020;
    for (int c = 0; c < 64; c++) begin
      if (!a_out_valid) break;
      check_val("scan2_tail_D", a_D, exp_d);
      exp_d = exp_d << 1;
      beats++;
      step();
    end
    check_val("scan2_tail_beats", beats, 32'd27);
    check_val("scan2_tail_busy", {31'b0, a_busy}, 32'd0);

    // Reset at the second beat of a scan
    a_in_valid = 1'b1; A = 5'd2; mode = 1'b1;
    step();
    a_in_valid = 1'b0; mode = 1'b0;
    step();
    check_val("rstscan_b3", a_D, 32'h0000_0008);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rstscan_valid", {31'b0, a_out_valid}, 32'd0);
    check_val("rstscan_D", a_D, 32'd0);
    check_val("rstscan_busy", {31'b0, a_busy}, 32'd0);
    check_val("rstscan_ready", {31'b0, a_in_ready}, 32'd1);
    a_in_valid = 1'b1; A = 5'd0;
    step();
    a_in_valid = 1'b0;
    check_val("rstscan_dec0", a_D, 32'h0000_0001);
    step();
    check_val("rstscan_idle", {31'b0, a_out_valid}, 32'd0);
`else
    // Without the scan feature mode is ignored
    a_in_valid = 1'b1; A = 5'd4; mode = 1'b1;
    step();
    a_in_valid = 1'b0; mode = 1'b0;
    check_val("noscan_D", a_D, 32'h0000_0010);
    check_val("noscan_err", {31'b0, a_err}, 32'd0);
    check_val("noscan_busy", {31'b0, a_busy}, 32'd0);
    check_val("noscan_ready", {31'b0, a_in_ready}, 32'd1);
    step();
    check_val("noscan_single", {31'b0, a_out_valid}, 32'd0);
    check_val("noscan_busy2", {31'b0, a_busy}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
